// File: rtl/fwd_hazard_unit.sv
// Operand forwarding plus a per-register latency scoreboard for multi-cycle producers.
// Optional stall-cycle performance counter is enabled by defining FWD_PERF_CNT_EN.
module fwd_hazard_unit #(
  parameter  int unsigned REG_ADDR_W = 5,
  parameter  int unsigned MAX_LAT    = 15,
  localparam int unsigned LAT_W      = $clog2(MAX_LAT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] idex_rs1,
  input  logic [REG_ADDR_W-1:0] idex_rs2,
  input  logic                  idex_use_rs1,
  input  logic                  idex_use_rs2,
  input  logic                  issue_valid,
  input  logic                  issue_regwr,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [LAT_W-1:0]      issue_lat,
  input  logic                  exmem_regwr,
  input  logic                  memwb_regwr,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic                  flush,
  output logic [1:0]            forwardA,
  output logic [1:0]            forwardB,
  output logic                  stall,
  output logic                  busy_any
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  localparam int unsigned      NREG      = 2 ** REG_ADDR_W;
  localparam logic [LAT_W-1:0] MAX_LAT_V = LAT_W'(MAX_LAT);

  logic [LAT_W-1:0] cnt [NREG];
  logic [LAT_W-1:0] latSat;
  logic             accept;
  logic             rs1Busy;
  logic             rs2Busy;

  function automatic logic [1:0] fwdSel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  useRs,
    input logic                  exWr,
    input logic [REG_ADDR_W-1:0] exRd,
    input logic                  memWr,
    input logic [REG_ADDR_W-1:0] memRd
  );
    logic hitEx;
    logic hitMem;
    hitEx  = exWr  && (exRd  != '0) && (exRd  == rs) && useRs;
    hitMem = memWr && (memRd != '0) && (memRd == rs) && useRs;
    if (hitEx)       return 2'b10;
    else if (hitMem) return 2'b01;
    else             return 2'b00;
  endfunction

  always_comb begin
    forwardA = fwdSel(idex_rs1, idex_use_rs1, exmem_regwr, exmem_rd, memwb_regwr, memwb_rd);
    forwardB = fwdSel(idex_rs2, idex_use_rs2, exmem_regwr, exmem_rd, memwb_regwr, memwb_rd);
  end

  always_comb begin
    rs1Busy = idex_use_rs1 && (cnt[idex_rs1] != '0);
    rs2Busy = idex_use_rs2 && (cnt[idex_rs2] != '0);
    stall   = rs1Busy || rs2Busy;
    accept  = issue_valid && !stall && !flush;
    latSat  = (issue_lat > MAX_LAT_V) ? MAX_LAT_V : issue_lat;
  end

  always_comb begin
    busy_any = 1'b0;
    for (int unsigned r = 0; r < NREG; r++) begin
      busy_any = busy_any | (cnt[r] != '0);
    end
  end

  // Entry 0 is rewritten to zero every cycle so x0 can never stall a reader.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        if (r == 0 || flush) begin
          cnt[r] <= '0;
        end else if (accept && issue_regwr && issue_rd == REG_ADDR_W'(r)) begin
          cnt[r] <= latSat;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - LAT_W'(1);
        end
      end
    end
  end

`ifdef FWD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: forwarding vector table plus scoreboard sequences.
// Build with FWD_PERF_CNT_EN defined to also check the stall-cycle counter.
module tb_fwd_hazard_unit;

  localparam int unsigned RW = 5;
  localparam int unsigned LW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW-1:0] idex_rs1, idex_rs2, issue_rd, exmem_rd, memwb_rd;
  logic          idex_use_rs1, idex_use_rs2, issue_valid, issue_regwr;
  logic [LW-1:0] issue_lat;
  logic          exmem_regwr, memwb_regwr, flush;
  logic [1:0]    forwardA, forwardB;
  logic          stall, busy_any;
`ifdef FWD_PERF_CNT_EN
  logic [31:0]   stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.REG_ADDR_W(RW), .MAX_LAT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .idex_rs1(idex_rs1), .idex_rs2(idex_rs2),
    .idex_use_rs1(idex_use_rs1), .idex_use_rs2(idex_use_rs2),
    .issue_valid(issue_valid), .issue_regwr(issue_regwr),
    .issue_rd(issue_rd), .issue_lat(issue_lat),
    .exmem_regwr(exmem_regwr), .memwb_regwr(memwb_regwr),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .flush(flush),
    .forwardA(forwardA), .forwardB(forwardB),
    .stall(stall), .busy_any(busy_any)
`ifdef FWD_PERF_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  typedef struct {
    logic [RW-1:0] rs1, rs2;
    logic          use1, use2;
    logic          exWr;
    logic [RW-1:0] exRd;
    logic          memWr;
    logic [RW-1:0] memRd;
    logic [1:0]    expA, expB;
  } fwdVec_t;

  fwdVec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    idex_rs1 = '0; idex_rs2 = '0; idex_use_rs1 = 1'b0; idex_use_rs2 = 1'b0;
    issue_valid = 1'b0; issue_regwr = 1'b0; issue_rd = '0; issue_lat = '0;
    exmem_regwr = 1'b0; memwb_regwr = 1'b0; exmem_rd = '0; memwb_rd = '0;
    flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [RW-1:0] rd, input logic [LW-1:0] lat);
    issue_valid = 1'b1; issue_regwr = 1'b1; issue_rd = rd; issue_lat = lat;
    step();
    issue_valid = 1'b0; issue_regwr = 1'b0;
  endtask

  int n;

  initial begin
    //            rs1 rs2 u1 u2 exW exRd memW memRd  A      B
    vecs[0] = '{5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 5'd0, 2'b10, 2'b00};
    vecs[1] = '{5'd5, 5'd0, 1, 0, 0, 5'd0, 1, 5'd5, 2'b01, 2'b00};
    vecs[2] = '{5'd7, 5'd7, 1, 1, 1, 5'd7, 1, 5'd7, 2'b10, 2'b10};
    vecs[3] = '{5'd0, 5'd0, 1, 1, 1, 5'd0, 1, 5'd0, 2'b00, 2'b00};
    vecs[4] = '{5'd5, 5'd5, 0, 0, 1, 5'd5, 1, 5'd5, 2'b00, 2'b00};
    vecs[5] = '{5'd5, 5'd9, 1, 1, 0, 5'd5, 1, 5'd5, 2'b01, 2'b00};
    vecs[6] = '{5'd5, 5'd3, 1, 1, 1, 5'd3, 1, 5'd5, 2'b01, 2'b10};
    vecs[7] = '{5'd31, 5'd31, 1, 1, 0, 5'd31, 0, 5'd31, 2'b00, 2'b00};

    idle();
    rst_n = 1'b0;
    #12;
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_busy", 32'(busy_any), 32'd0);
    chk("reset_fwdA", 32'(forwardA), 32'd0);
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      idex_rs1 = vecs[i].rs1; idex_rs2 = vecs[i].rs2;
      idex_use_rs1 = vecs[i].use1; idex_use_rs2 = vecs[i].use2;
      exmem_regwr = vecs[i].exWr; exmem_rd = vecs[i].exRd;
      memwb_regwr = vecs[i].memWr; memwb_rd = vecs[i].memRd;
      #1;
      chk($sformatf("vec%0d_fwdA", i), 32'(forwardA), 32'(vecs[i].expA));
      chk($sformatf("vec%0d_fwdB", i), 32'(forwardB), 32'(vecs[i].expB));
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'd0);
    end
    idle();
    step();

    // Load-use: one bubble, then forward from EX/MEM
    issue(5'd3, 4'd1);
    idex_rs1 = 5'd3; idex_use_rs1 = 1'b1;
    #1;
    chk("ld_use_stall", 32'(stall), 32'd1);
    step();
    exmem_regwr = 1'b1; exmem_rd = 5'd3;
    #1;
    chk("ld_use_release", 32'(stall), 32'd0);
    chk("ld_use_fwdA", 32'(forwardA), 32'd2);
    idle();

    // lat = 0 never stalls
    issue(5'd8, 4'd0);
    idex_rs1 = 5'd8; idex_use_rs1 = 1'b1;
    #1;
    chk("lat0_stall", 32'(stall), 32'd0);
    chk("lat0_busy", 32'(busy_any), 32'd0);
    idle();

    // Asynchronous reset mid-countdown
    issue(5'd9, 4'd10);
    repeat (4) step();
    idex_rs2 = 5'd9; idex_use_rs2 = 1'b1;
    #1;
    chk("pre_rst_stall", 32'(stall), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_busy", 32'(busy_any), 32'd0);
`ifdef FWD_PERF_CNT_EN
    chk("perf_reset", stall_cycles, 32'd0);
`endif
    idle();
    step();
    rst_n = 1'b1;
    step();

    // Divide lat=10: exactly 10 stall cycles; blocked issue must be dropped
    issue(5'd9, 4'd10);
    idex_rs2 = 5'd9; idex_use_rs2 = 1'b1;
    issue_valid = 1'b1; issue_regwr = 1'b1; issue_rd = 5'd12; issue_lat = 4'd15;
    #1;
    n = 0;
    while (stall && n < 50) begin
      n++;
      @(posedge clk);
      #1;
    end
    issue_valid = 1'b0; issue_regwr = 1'b0;
    #1;
    chk("div_stall_cycles", 32'(n), 32'd10);
    chk("div_blocked_issue", 32'(busy_any), 32'd0);
`ifdef FWD_PERF_CNT_EN
    chk("perf_div", stall_cycles, 32'd10);
`endif
    idle();

    issue(5'd9, 4'd10);
    idex_rs2 = 5'd9; idex_use_rs2 = 1'b0;
    #1;
    chk("div_unused_stall", 32'(stall), 32'd0);
    chk("div_unused_busy", 32'(busy_any), 32'd1);
    repeat (10) step();
    chk("div_drained", 32'(busy_any), 32'd0);

    // WAW: later write of x4 overrides the pending latency
    issue(5'd4, 4'd8);
    step();
    issue(5'd4, 4'd1);
    idex_rs1 = 5'd4; idex_use_rs1 = 1'b1;
    #1;
    chk("waw_stall", 32'(stall), 32'd1);
    step();
    chk("waw_release", 32'(stall), 32'd0);
    chk("waw_busy", 32'(busy_any), 32'd0);
    idle();

    // Flush clears pending counters and drops the same-cycle issue
    issue(5'd6, 4'd5);
    issue_valid = 1'b1; issue_regwr = 1'b1; issue_rd = 5'd7; issue_lat = 4'd3;
    flush = 1'b1;
    #1;
    chk("flush_pre_busy", 32'(busy_any), 32'd1);
    step();
    idle();
    idex_rs1 = 5'd7; idex_use_rs1 = 1'b1;
    idex_rs2 = 5'd6; idex_use_rs2 = 1'b1;
    #1;
    chk("flush_busy", 32'(busy_any), 32'd0);
    chk("flush_stall", 32'(stall), 32'd0);
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
